// File: rtl/prog_loader.sv
// Boot-time program loader: assembles little-endian words from a byte stream and
// writes them to instruction memory, holding the CPU in reset. Option: PROG_LOADER_CSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  // state  | meaning
  // LEN_LO | waiting for word count low byte
  // LEN_HI | waiting for word count high byte, range check
  // DATA   | collecting payload bytes, one write per 4 bytes
  // CSUM   | waiting for trailing XOR byte (optional)
  // WAIT   | final write drains
  // RUN    | image loaded, CPU released
  // ERR    | malformed image, CPU held in reset
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_WAIT, S_RUN, S_ERR
  } state_t;

  localparam int MAX_WORDS = 1 << ADDR_W;
  localparam int CW        = ADDR_W + 1;

  state_t              r_state, w_next;
  logic [15:0]         r_len;
  logic [1:0]          r_byte_idx;
  logic [CW-1:0]       r_word_cnt;
  logic [23:0]         r_asm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_in_ready, r_cpu_rst, r_done, r_error;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]          r_csum;
`endif

  logic        w_xfer, w_len_bad, w_last_word, w_ready_nxt;
  logic [15:0] w_len_full;

  assign w_xfer      = in_valid & r_in_ready;
  assign w_len_full  = {in_data, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || (32'(w_len_full) > MAX_WORDS);
  assign w_last_word = (r_byte_idx == 2'd3) && ((32'(r_word_cnt) + 32'd1) == 32'(r_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LEN_LO;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
      S_DATA: begin
        if (w_xfer && w_last_word) begin
`ifdef PROG_LOADER_CSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_WAIT;
`endif
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM:   if (w_xfer) w_next = (in_data == r_csum) ? S_WAIT : S_ERR;
`endif
      S_WAIT:   w_next = S_RUN;
      S_RUN:    w_next = S_RUN;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_ERR;
    endcase
  end

  // in_ready tracks the upcoming state so it is low during reset and high one cycle after
  always_comb begin
    w_ready_nxt = 1'b0;
    case (w_next)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: w_ready_nxt = 1'b1;
      default:                            w_ready_nxt = 1'b0;
    endcase
  end

  // Status lags RUN by one cycle so release lands two edges after the last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_in_ready <= w_ready_nxt;
      r_cpu_rst  <= (r_state != S_RUN);
      r_done     <= (r_state == S_RUN);
      r_error    <= (r_state == S_ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
`ifdef PROG_LOADER_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_LEN_LO: r_len[7:0]  <= in_data;
          S_LEN_HI: r_len[15:8] <= in_data;
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef PROG_LOADER_CSUM_EN
            r_csum     <= r_csum ^ in_data;
`endif
            if (r_byte_idx == 2'd3) begin
              r_we       <= 1'b1;
              r_addr     <= r_word_cnt[ADDR_W-1:0];
              r_wdata    <= {in_data, r_asm};
              r_word_cnt <= r_word_cnt + 1'b1;
            end else begin
              r_asm[8*r_byte_idx +: 8] <= in_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign done       = r_done;
  assign error      = r_error;

endmodule
